// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - select-line scanner for a downstream 4:1 mux with settle delay
module mux_sel_scanner #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [3:0] chan_mask,
    output logic       s1,
    output logic       s0,
    output logic       sample_valid,
    output logic [1:0] chan_id,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic       cont_q, cont_d;
    logic       sv_q, sv_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [1:0] next_ch;
    logic [1:0] cand;
    logic       found;

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Search sel+1, sel+2, sel+3 and finally sel itself, so a lone channel selects itself.
    always_comb begin
        next_ch = sel_q;
        cand    = sel_q;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = sel_q + 2'(i);
            if (!found && mask_q[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        sv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (chan_mask != 4'd0) begin
                        mask_d  = chan_mask;
                        cont_d  = cont;
                        sel_d   = lowest_chan(chan_mask);
                        cnt_d   = RELOAD;
                        state_d = SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                    sv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!cont_q && (next_ch <= sel_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sel_d   = next_ch;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 4'd0;
            cont_q  <= 1'b0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s1           = sel_q[1];
    assign s0           = sel_q[0];
    assign chan_id      = sel_q;
    assign sample_valid = sv_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - directed self-checking bench for mux_sel_scanner
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] chan_mask;
    logic       s1;
    logic       s0;
    logic       sample_valid;
    logic [1:0] chan_id;
    logic       busy;
    logic       done;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    mux_sel_scanner #(.SETTLE_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cont         (cont),
        .chan_mask    (chan_mask),
        .s1           (s1),
        .s0           (s0),
        .sample_valid (sample_valid),
        .chan_id      (chan_id),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {sample_valid, s1, s0, chan_id, busy, done, err}
    function automatic logic [7:0] e(input logic sv, input logic [1:0] ch,
                                     input logic bz, input logic dn, input logic er);
        return {sv, ch, ch, bz, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {sample_valid, s1, s0, chan_id, busy, done, err};
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet(input string tag, input int n, input logic [1:0] ch);
        repeat (n) begin
            step(1);
            chk(tag, e(1'b0, ch, 1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cont = 1'b0;
        chan_mask = 4'd0;
        #2;
        chk("reset_state", e(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        step(1);
        rst_n = 1'b1;

        // Single pass over all four channels
        chan_mask = 4'b1111; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("all_start", e(1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
        quiet("all_settle0", 3, 2'd0);
        step(1);
        chk("all_sample0", e(1'b1, 2'd0, 1'b1, 1'b0, 1'b0));
        for (int c = 1; c < 4; c++) begin
            quiet("all_settle", 4, 2'(c));
            step(1);
            chk("all_sample", e(1'b1, 2'(c), 1'b1, 1'b0, 1'b0));
        end
        step(1);
        chk("all_done", e(1'b0, 2'd3, 1'b0, 1'b1, 1'b0));
        step(1);
        chk("all_done_clear", e(1'b0, 2'd3, 1'b0, 1'b0, 1'b0));

        // Continuous scan over channels 1 and 3, stopped during the third sample
        chan_mask = 4'b1010; cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("alt_start", e(1'b0, 2'd1, 1'b1, 1'b0, 1'b0));
        quiet("alt_settle1", 3, 2'd1);
        step(1);
        chk("alt_sample1", e(1'b1, 2'd1, 1'b1, 1'b0, 1'b0));
        quiet("alt_settle3", 4, 2'd3);
        step(1);
        chk("alt_sample3", e(1'b1, 2'd3, 1'b1, 1'b0, 1'b0));
        quiet("alt_settle1b", 4, 2'd1);
        step(1);
        chk("alt_sample1b", e(1'b1, 2'd1, 1'b1, 1'b0, 1'b0));
        stop = 1'b1;
        step(1);
        chk("alt_stopped", e(1'b0, 2'd1, 1'b0, 1'b0, 1'b0));
        stop = 1'b0;
        step(1);
        chk("alt_no_done", e(1'b0, 2'd1, 1'b0, 1'b0, 1'b0));

        // Lone channel 2, single pass then continuous
        chan_mask = 4'b0100; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("one_start", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        quiet("one_settle", 3, 2'd2);
        step(1);
        chk("one_sample", e(1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        step(1);
        chk("one_done", e(1'b0, 2'd2, 1'b0, 1'b1, 1'b0));
        step(1);
        chk("one_idle", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));

        cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("onec_start", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        quiet("onec_settle", 3, 2'd2);
        step(1);
        chk("onec_sample1", e(1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        quiet("onec_resettle", 4, 2'd2);
        step(1);
        chk("onec_sample2", e(1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        step(1);
        chk("onec_settle3", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        stop = 1'b1;
        step(1);
        chk("onec_stop_settle", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
        stop = 1'b0;

        // Empty mask errors; start with stop is ignored
        chan_mask = 4'b0000; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("err_pulse", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b1));
        step(1);
        chk("err_clear", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
        chan_mask = 4'b1111; start = 1'b1; stop = 1'b1;
        step(1);
        chk("start_stop_ignored", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
        start = 1'b0; stop = 1'b0;
        step(1);
        chk("start_stop_idle", e(1'b0, 2'd2, 1'b0, 1'b0, 1'b0));

        // Start and new mask while busy are ignored
        chan_mask = 4'b1100; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_start", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        step(1);
        chan_mask = 4'b0011; cont = 1'b1; start = 1'b1;
        step(1);
        chk("busy_restart_ign", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        start = 1'b0;
        step(1);
        chk("busy_settle", e(1'b0, 2'd2, 1'b1, 1'b0, 1'b0));
        step(1);
        chk("busy_sample2", e(1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        quiet("busy_settle3", 4, 2'd3);
        step(1);
        chk("busy_sample3", e(1'b1, 2'd3, 1'b1, 1'b0, 1'b0));
        step(1);
        chk("busy_done", e(1'b0, 2'd3, 1'b0, 1'b1, 1'b0));

        // Asynchronous reset mid-settle on channel 3
        chan_mask = 4'b1000; cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rst_scan_start", e(1'b0, 2'd3, 1'b1, 1'b0, 1'b0));
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", e(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        step(1);
        rst_n = 1'b1;
        chk("rst_held", e(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_no_done", e(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        end
        chan_mask = 4'b0010; cont = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("post_rst_start", e(1'b0, 2'd1, 1'b1, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_sel_scanner.md
MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 4, legal range 1..15: the number of cycles to wait after a select change before sampling the downstream 4:1 mux output.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: a scan request, sampled only in IDLE.
REQ-005 SHALL provide port stop, input, 1 bit: aborts an active scan.
REQ-006 SHALL provide port cont, input, 1 bit: 1 = continuous scan, 0 = single pass; latched on an accepted start.
REQ-007 SHALL provide port chan_mask, input, 4 bits: bit n enables channel n (i0..i3); latched on an accepted start.
REQ-008 SHALL provide ports s1 and s0, output, 1 bit each: the registered select lines to the downstream 4:1 mux, with channel = {s1,s0}.
REQ-009 SHALL provide port sample_valid, output, 1 bit: a one-cycle strobe meaning the mux output is settled and may be captured.
REQ-010 SHALL provide port chan_id, output, 2 bits: the channel currently selected, always equal to {s1,s0}.
REQ-011 SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL provide ports done and err, output, 1 bit each: one-cycle status pulses.

Function
REQ-013 SHALL implement an FSM with the states IDLE, SETTLE and SAMPLE; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 with stop=0 and a nonzero chan_mask SHALL, at that edge, latch the mask and cont, load {s1,s0} with the lowest enabled channel, load the 4-bit counter with SETTLE_CYC-1, and enter SETTLE.
REQ-015 In IDLE, start=1 with chan_mask=0 SHALL pulse err for one cycle and remain in IDLE with the select lines unchanged.
REQ-016 In IDLE, start=1 together with stop=1 SHALL be ignored: no state change, no err.
REQ-017 SETTLE SHALL decrement the counter each cycle and enter SAMPLE on the edge where the counter equals 0, so that SETTLE lasts exactly SETTLE_CYC cycles.
REQ-018 SAMPLE SHALL last one cycle with sample_valid=1; sample_valid SHALL be 0 in every other state.
REQ-019 Timing: for a start accepted at edge k, sample_valid SHALL be high between edges k+SETTLE_CYC and k+SETTLE_CYC+1; the sample period SHALL be SETTLE_CYC+1 cycles.
REQ-020 On leaving SAMPLE, the next channel SHALL be the next enabled channel in ascending order after the current one, wrapping from 3 to 0; the current channel counts as the next channel when it is the only one enabled.
REQ-021 With cont=0, if the next channel is less than or equal to the current channel (a wrap), the block SHALL enter IDLE, pulse done for one cycle and hold {s1,s0}.
REQ-022 Otherwise the block SHALL update {s1,s0} to the next channel, reload the counter with SETTLE_CYC-1, and enter SETTLE; SETTLE SHALL be re-applied even when the channel is unchanged.
REQ-023 stop=1 in SETTLE or SAMPLE SHALL force IDLE at the next edge; sample_valid, done and err SHALL be 0 from then on, and {s1,s0} SHALL be held.
REQ-024 stop=1 in SAMPLE SHALL still allow that cycle's sample_valid=1, which was already registered.
REQ-025 Changes to chan_mask or cont while busy SHALL have no effect until the next accepted start; a start while busy SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force IDLE with s1=0, s0=0, chan_id=0, sample_valid=0, busy=0, done=0, err=0, counter=0 and latched mask=0.
REQ-027 After rst_n deasserts, the block SHALL accept start no earlier than the first rising edge of clk.
REQ-028 Reset asserted mid-scan SHALL discard the scan: no done pulse.

Verification
REQ-029 Scenario: SETTLE_CYC=4, mask=1111, cont=0, 1-cycle start -> sample_valid pulses with chan_id 0,1,2,3 spaced 5 cycles apart, the first 4 cycles after the start edge; done 1 cycle after the last pulse; busy then low.
REQ-030 Scenario: mask=1010, cont=1 -> chan_id sequence 1,3,1,3,...; stop after the 3rd pulse -> busy low at the next edge, {s1,s0} held, no done.
REQ-031 Scenario: mask=0100, cont=0 -> exactly one sample_valid with chan_id=2, then done; with cont=1 -> repeated chan_id=2 every 5 cycles.
REQ-032 Scenario: mask=0000 with start -> one-cycle err pulse, busy stays 0; start and stop together in IDLE -> no change.
REQ-033 Scenario: rst_n low mid-SETTLE with {s1,s0}=11 -> all outputs 0 before the next clk edge; no done.
REQ-034 Scenario: start with mask=0011 while busy -> ignored; the scan continues on the original mask to completion.
